// File: rtl/vga_rx.sv
// vga_rx: recovers pixel coordinates from a VGA-style hsync/vsync/RGB stream,
// locks onto the expected line/frame timing and flags timing violations.
// Optional build macro VGA_RX_FRAME_SIG_EN adds a per-frame pixel signature;
// without it frame_sig is tied to zero.
module vga_rx #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int H_VIS        = 640,
  parameter int V_VIS        = 480,
  parameter int H_SYNC_START = 657,
  parameter int V_SYNC_START = 491
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ena,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [1:0]  r,
  input  logic [1:0]  g,
  input  logic [1:0]  b,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [5:0]  px_rgb,
  output logic        px_valid,
  output logic        locked,
  output logic        frame_start,
  output logic        sync_err,
  output logic [15:0] frame_sig
);

  localparam logic [9:0]  X_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  X_SYNC  = 10'(H_SYNC_START);
  localparam logic [9:0]  Y_SYNC  = 10'(V_SYNC_START);
  localparam logic [10:0] H_LEN   = 11'(H_TOTAL);
  localparam logic [9:0]  V_LEN   = 10'(V_TOTAL);
  localparam logic [9:0]  X_VIS   = 10'(H_VIS);
  localparam logic [9:0]  Y_VIS   = 10'(V_VIS);
  localparam logic [9:0]  CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state, state_nxt;
  logic        s_hs, s_vs;
  logic [5:0]  s_rgb;
  logic [9:0]  x_cnt, y_cnt, hlen, vlen;
  logic [9:0]  x_nxt, y_nxt, hlen_nxt, vlen_nxt;
  logic        h_armed, armed_nxt;
  logic        line_edge, frame_edge, viol, fs_nxt;

  // Saturating increment for the line-length and line counters.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  // Next-state evaluation: edge detection, counters, violation check, FSM.
  always_comb begin
    line_edge  = s_hs & ~hsync;
    frame_edge = s_vs & ~vsync;

    x_nxt = x_cnt;
    if (line_edge)            x_nxt = X_SYNC;
    else if (x_cnt == X_LAST) x_nxt = 10'd0;
    else                      x_nxt = x_cnt + 10'd1;

    y_nxt = y_cnt;
    if (frame_edge)
      y_nxt = Y_SYNC;
    else if (!line_edge && (x_cnt == X_LAST))
      y_nxt = (y_cnt == Y_LAST) ? 10'd0 : y_cnt + 10'd1;

    hlen_nxt = line_edge ? 10'd0 : sat_inc(hlen);
    vlen_nxt = frame_edge ? 10'd0 : (line_edge ? sat_inc(vlen) : vlen);

    // The first partial line after leaving SEARCH is not judged (h_armed=0);
    // the partial frame is covered because vlen restarts at the entry edge.
    viol = 1'b0;
    if (state != SEARCH) begin
      if (line_edge && h_armed && (({1'b0, hlen} + 11'd1) != H_LEN)) viol = 1'b1;
      if (!line_edge && h_armed && (hlen == CNT_MAX - 10'd1))        viol = 1'b1;
      if (frame_edge && (vlen != V_LEN))                             viol = 1'b1;
    end

    state_nxt = state;
    case (state)
      SEARCH:  if (frame_edge) state_nxt = TRACK;
      TRACK:   if (viol) state_nxt = SEARCH; else if (frame_edge) state_nxt = LOCKED;
      LOCKED:  if (viol) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase

    armed_nxt = h_armed;
    if (state_nxt == SEARCH)               armed_nxt = 1'b0;
    else if (line_edge && state != SEARCH) armed_nxt = 1'b1;

    fs_nxt = (state_nxt == LOCKED) && (x_nxt == 10'd0) && (y_nxt == 10'd0);
  end

  // Input sampling, position counters and the frame_start pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_hs        <= 1'b1;
      s_vs        <= 1'b1;
      s_rgb       <= 6'd0;
      x_cnt       <= 10'd0;
      y_cnt       <= 10'd0;
      hlen        <= 10'd0;
      vlen        <= 10'd0;
      frame_start <= 1'b0;
    end else if (ena) begin
      s_hs        <= hsync;
      s_vs        <= vsync;
      s_rgb       <= {r, g, b};
      x_cnt       <= x_nxt;
      y_cnt       <= y_nxt;
      hlen        <= hlen_nxt;
      vlen        <= vlen_nxt;
      frame_start <= fs_nxt;
    end else begin
      frame_start <= 1'b0;
    end
  end

  // Lock FSM with registered locked and sync_err outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEARCH;
      h_armed  <= 1'b0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else if (ena) begin
      state    <= state_nxt;
      h_armed  <= armed_nxt;
      locked   <= (state_nxt == LOCKED);
      sync_err <= viol;
    end else begin
      sync_err <= 1'b0;
    end
  end

  assign px_x     = x_cnt;
  assign px_y     = y_cnt;
  assign px_rgb   = s_rgb;
  assign px_valid = locked & (x_cnt < X_VIS) & (y_cnt < Y_VIS);

`ifdef VGA_RX_FRAME_SIG_EN
  logic [15:0] sig, sig_upd, frame_sig_q;

  always_comb begin
    sig_upd = sig;
    if (px_valid) sig_upd = {sig[14:0], sig[15]} ^ {10'b0, px_rgb};
  end

  // Rotate-xor signature over the visible pixels, published at frame_start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sig         <= 16'h0000;
      frame_sig_q <= 16'h0000;
    end else if (ena) begin
      if (fs_nxt) begin
        frame_sig_q <= sig_upd;
        sig         <= 16'h0000;
      end else begin
        sig         <= sig_upd;
      end
    end
  end

  assign frame_sig = frame_sig_q;
`else
  assign frame_sig = 16'h0000;
`endif

endmodule
